// File: rtl/writeback_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// writeback_arbiter : merges ALU and long-latency results onto the register
//                     file write port; tracks outstanding long-latency dests.
// Revision 1.0
// ---------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_waddr,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        alu_hold,
  output logic        w_en,
  output logic [4:0]  waddr,
  output logic [31:0] data_in
);

  localparam logic [3:0] HOLD_AT = 4'(STARVE_LIMIT);

  logic [31:0] sb;
  logic [31:0] sb_next;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_next;
  logic        hold_next;
  logic        mem_accept;
  logic        sel_valid;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  assign mem_ready  = !alu_valid;
  assign mem_accept = mem_valid && mem_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = alu_waddr;
    sel_data  = alu_data;
    if (alu_valid) begin
      sel_valid = 1'b1;
    end else if (mem_valid) begin
      sel_valid = 1'b1;
      sel_addr  = mem_waddr;
      sel_data  = mem_data;
    end
  end

  // Set is applied after clear so a same-cycle issue to that register wins.
  always_comb begin
    sb_next = sb;
    if (mem_accept)
      sb_next[mem_waddr] = 1'b0;
    if (issue_valid && issue_long && issue_waddr != 5'd0)
      sb_next[issue_waddr] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_comb begin
    starve_next = starve_cnt;
    hold_next   = alu_hold;
    if (!mem_valid || mem_accept) begin
      starve_next = 4'd0;
      hold_next   = 1'b0;
    end else begin
      if (starve_cnt != 4'hF)
        starve_next = starve_cnt + 4'd1;
      if (starve_next == HOLD_AT)
        hold_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_en       <= 1'b0;
      waddr      <= 5'd0;
      data_in    <= 32'd0;
      sb         <= 32'd0;
      starve_cnt <= 4'd0;
      alu_hold   <= 1'b0;
    end else begin
      w_en       <= sel_valid && sel_addr != 5'd0;
      if (sel_valid && sel_addr != 5'd0) begin
        waddr   <= sel_addr;
        data_in <= sel_data;
      end
      sb         <= sb_next;
      starve_cnt <= starve_next;
      alu_hold   <= hold_next;
    end
  end

  // The in-flight term covers the cycle between accept and the regfile write.
  assign rs_busy = sb[rs_addr] | (w_en && waddr == rs_addr && rs_addr != 5'd0);
  assign rt_busy = sb[rt_addr] | (w_en && waddr == rt_addr && rt_addr != 5'd0);

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that drives the single write port of the processor's 32x32 register file. Merges single-cycle ALU results with handshaked long-latency results (loads, multiply/divide) onto one registered write port. Keeps a 32-bit scoreboard of destinations with outstanding long-latency results, so decode can stall on read-after-write hazards. Bounds starvation of the long-latency path with a hold request to the pipeline.

## Interface
- STARVE_LIMIT, 4, consecutive cycles a pending long-latency result may lose arbitration before `alu_hold` is raised; legal range 1..15.

- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU result present this cycle; no backpressure, always accepted
- alu_waddr  input  5  ALU destination register
- alu_data  input  32  ALU result
- mem_valid  input  1  long-latency result present; held stable by source until accepted
- mem_waddr  input  5  long-latency destination register
- mem_data  input  32  long-latency result
- mem_ready  output  1  long-latency result accepted this cycle when high with mem_valid
- issue_valid  input  1  decode issuing an instruction this cycle
- issue_long  input  1  issued instruction completes through the mem_* path
- issue_waddr  input  5  destination of the issued instruction
- rs_addr  input  5  decode source register rs
- rt_addr  input  5  decode source register rt
- rs_busy  output  1  rs value not yet in the register file
- rt_busy  output  1  rt value not yet in the register file
- alu_hold  output  1  request that decode issue no ALU writeback next cycle
- w_en  output  1  register file write enable (registered)
- waddr  output  5  register file write address (registered)
- data_in  output  32  register file write data (registered)

## Operation
- Arbitration, combinational: `mem_ready = !alu_valid`. ALU has fixed priority; a long-latency result is accepted in any cycle with no ALU result.
- Write selection: ALU result if alu_valid, else the mem result if mem_valid, else none. The selected result is registered into waddr/data_in, with w_en = 1 when the destination is not 0.
- Destination 0: the result is accepted/consumed normally but never written. w_en = 0; waddr/data_in hold their previous values.
- Idle cycles: w_en = 0; waddr/data_in hold.
- Scoreboard (32 bits, bit 0 hard-wired 0):
  - Set bit issue_waddr on issue_valid && issue_long && issue_waddr != 0.
  - Clear bit mem_waddr on mem accept (mem_valid && mem_ready).
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes never modify the scoreboard.
- Busy, combinational: `rs_busy = sb[rs_addr] | (w_en && waddr == rs_addr && rs_addr != 0)`; `rt_busy` likewise. The second term covers the cycle in which the write is still in flight to the register file.
- Starvation counter (4 bits):
  - Increments each cycle with mem_valid && alu_valid, saturating at 15.
  - Clears on mem accept or when !mem_valid.
- alu_hold (registered):
  - Set on the edge where the counter reaches STARVE_LIMIT.
  - Cleared on the edge following a mem accept, or when mem_valid drops.
  - Advisory only: if alu_valid arrives anyway, the ALU still wins and alu_hold stays high.
- Reset (synchronous, overrides everything in that cycle): w_en=0, waddr=0, data_in=0, scoreboard all 0, counter 0, alu_hold=0. mem_ready follows alu_valid even during reset, but an accept during reset is discarded. Any in-flight long-latency op is forgotten; its source must also be reset.

## Timing
- Latency: result accepted at edge N -> w_en/waddr/data_in valid after edge N, so the register file is written at edge N+1.
- Throughput: one write per cycle.
- Scoreboard:
  - A set at edge N makes busy visible the cycle after N.
  - A clear at accept edge N: busy stays high one more cycle through the in-flight term, then drops after N+1.
- alu_hold is first visible the cycle after the counter hits STARVE_LIMIT. The earliest possible mem accept is the following cycle.

## Test plan
- Reset then idle: assert reset 2 cycles -> w_en=0, waddr=0, data_in=0, alu_hold=0. Then rs_addr=5 -> rs_busy=0.
- ALU write: alu_valid, waddr=3, data=0xDEADBEEF for 1 cycle -> next cycle w_en=1, waddr=3, data_in=0xDEADBEEF; following cycle w_en=0. Repeat with waddr=0 -> w_en never asserted.
- Scoreboard: issue_long to r7, then rs_addr=7 -> rs_busy=1 from the next cycle. mem result r7=0x1234 accepted at edge N -> w_en=1 after N; rs_busy=1 through cycle N+1, 0 after.
- Collision: alu_valid and mem_valid both high one cycle -> mem_ready=0, ALU written. mem then accepted the next cycle -> back-to-back w_en for the two addresses in ALU-then-mem order.
- Starvation: STARVE_LIMIT=4, alu_valid and mem_valid held high -> alu_hold=1 after the 4th cycle. Drop alu_valid -> mem accepted; alu_hold=0 the cycle after the accept.
- Set/clear race plus reset mid-op: issue_long r9 in the same cycle as the mem accept for r9 -> rs_busy for r9 stays 1. Then reset -> rs_busy=0, alu_hold=0.
